amo_sequencer: RTL

- Sequences RISC-V A-extension AMO instructions (read-modify-write) for all harts of the barrel core. It uses the shared 12-bit word-addressed data memory port.
- Holds the memory port for one read, one compute and one write cycle.
- Returns the old memory value to the requesting hart.
- Signals the reservation set that a store has hit the address, so any LR/SC reservation there is cleared.

---
 rtl/amo_pkg.sv | 35 +++
 rtl/amo_alu.sv | 32 +++
 rtl/amo_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/amo_pkg.sv
// Shared definitions for the AMO sequencer: funct5 encodings, FSM states
// and the legality check used by the ALU.
package amo_pkg;

  localparam logic [4:0] AMO_ADD  = 5'b00000;
  localparam logic [4:0] AMO_SWAP = 5'b00001;
  localparam logic [4:0] AMO_LR   = 5'b00010;
  localparam logic [4:0] AMO_SC   = 5'b00011;
  localparam logic [4:0] AMO_XOR  = 5'b00100;
  localparam logic [4:0] AMO_OR   = 5'b01000;
  localparam logic [4:0] AMO_AND  = 5'b01100;
  localparam logic [4:0] AMO_MIN  = 5'b10000;
  localparam logic [4:0] AMO_MAX  = 5'b10100;
  localparam logic [4:0] AMO_MINU = 5'b11000;
  localparam logic [4:0] AMO_MAXU = 5'b11100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CALC  = 2'd2,
    WRITE = 2'd3
  } amo_state_e;

  // LR/SC are not handled here; they go through the reservation set.
  function automatic logic is_legal_amo(input logic [4:0] funct5);
    logic legal_s;
    case (funct5)
      AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND,
      AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: legal_s = 1'b1;
      default:                              legal_s = 1'b0;
    endcase
    return legal_s;
  endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational read-modify-write datapath for the AMO sequencer.
module amo_alu
  import amo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        funct5,
  input  logic [DATA_W-1:0] old,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] new_val,
  output logic              illegal
);

  // Result select; min/max keep old on equality, illegal codes pass old through.
  always_comb begin
    new_val = old;
    illegal = !is_legal_amo(funct5);
    case (funct5)
      AMO_ADD:  new_val = old + operand;
      AMO_SWAP: new_val = operand;
      AMO_XOR:  new_val = old ^ operand;
      AMO_OR:   new_val = old | operand;
      AMO_AND:  new_val = old & operand;
      AMO_MIN:  new_val = ($signed(operand) < $signed(old)) ? operand : old;
      AMO_MAX:  new_val = ($signed(operand) > $signed(old)) ? operand : old;
      AMO_MINU: new_val = (operand < old) ? operand : old;
      AMO_MAXU: new_val = (operand > old) ? operand : old;
      default:  new_val = old;
    endcase
  end

endmodule

// File: rtl/amo_sequencer.sv
// Read-modify-write sequencer for A-extension AMOs on the shared data port.
// Outputs are registered from the next-state decode, so they track the state.
module amo_sequencer
  import amo_pkg::*;
#(
  parameter int NUM_THREADS = 16,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  localparam int HW         = $clog2(NUM_THREADS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [4:0]        i_req_funct5,
  input  logic [DATA_W-1:0] i_req_operand,
  input  logic [HW-1:0]     i_req_hartid,
  output logic              o_busy,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_rs_store_op,
  output logic [ADDR_W-1:0] o_rs_addr,
  output logic              o_resp_valid,
  output logic [DATA_W-1:0] o_resp_data,
  output logic [HW-1:0]     o_resp_hartid,
  output logic              o_resp_err
);

  amo_state_e        state_r, state_next_s;
  logic [ADDR_W-1:0] addr_r;
  logic [4:0]        funct5_r;
  logic [DATA_W-1:0] operand_r;
  logic [HW-1:0]     hartid_r;

  logic [DATA_W-1:0] new_s;
  logic              illegal_s;

  logic              ready_s, busy_s, mem_en_s, mem_we_s, rs_store_s;
  logic              resp_valid_s, resp_err_s;
  logic [ADDR_W-1:0] mem_addr_s, rs_addr_s;
  logic [DATA_W-1:0] mem_wdata_s, resp_data_s;
  logic [HW-1:0]     resp_hartid_s;

  amo_alu #(.DATA_W(DATA_W)) u_alu (
    .funct5  (funct5_r),
    .old     (i_mem_rdata),
    .operand (operand_r),
    .new_val (new_s),
    .illegal (illegal_s)
  );

  // Next-state logic for the fixed READ/CALC/WRITE walk.
  always_comb begin
    state_next_s = IDLE;
    case (state_r)
      IDLE:    state_next_s = i_req_valid ? READ : IDLE;
      READ:    state_next_s = CALC;
      CALC:    state_next_s = WRITE;
      WRITE:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output values for the state being entered; the WRITE entry samples read data.
  always_comb begin
    ready_s       = 1'b0;
    busy_s        = 1'b0;
    mem_en_s      = 1'b0;
    mem_we_s      = 1'b0;
    mem_addr_s    = '0;
    mem_wdata_s   = '0;
    rs_store_s    = 1'b0;
    rs_addr_s     = '0;
    resp_valid_s  = 1'b0;
    resp_data_s   = '0;
    resp_hartid_s = '0;
    resp_err_s    = 1'b0;
    case (state_next_s)
      IDLE: ready_s = 1'b1;
      READ: begin
        busy_s     = 1'b1;
        mem_en_s   = 1'b1;
        mem_addr_s = i_req_addr;
      end
      CALC: busy_s = 1'b1;
      WRITE: begin
        busy_s        = 1'b1;
        mem_en_s      = !illegal_s;
        mem_we_s      = !illegal_s;
        mem_addr_s    = addr_r;
        mem_wdata_s   = new_s;
        rs_store_s    = !illegal_s;
        rs_addr_s     = addr_r;
        resp_valid_s  = 1'b1;
        resp_data_s   = i_mem_rdata;
        resp_hartid_s = hartid_r;
        resp_err_s    = illegal_s;
      end
      default: ready_s = 1'b0;
    endcase
  end

  // State register and request capture (only on accept).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      addr_r    <= '0;
      funct5_r  <= 5'd0;
      operand_r <= '0;
      hartid_r  <= '0;
    end else begin
      state_r <= state_next_s;
      if (state_r == IDLE && i_req_valid) begin
        addr_r    <= i_req_addr;
        funct5_r  <= i_req_funct5;
        operand_r <= i_req_operand;
        hartid_r  <= i_req_hartid;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_req_ready   <= 1'b1;
      o_busy        <= 1'b0;
      o_mem_en      <= 1'b0;
      o_mem_we      <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wdata   <= '0;
      o_rs_store_op <= 1'b0;
      o_rs_addr     <= '0;
      o_resp_valid  <= 1'b0;
      o_resp_data   <= '0;
      o_resp_hartid <= '0;
      o_resp_err    <= 1'b0;
    end else begin
      o_req_ready   <= ready_s;
      o_busy        <= busy_s;
      o_mem_en      <= mem_en_s;
      o_mem_we      <= mem_we_s;
      o_mem_addr    <= mem_addr_s;
      o_mem_wdata   <= mem_wdata_s;
      o_rs_store_op <= rs_store_s;
      o_rs_addr     <= rs_addr_s;
      o_resp_valid  <= resp_valid_s;
      o_resp_data   <= resp_data_s;
      o_resp_hartid <= resp_hartid_s;
      o_resp_err    <= resp_err_s;
    end
  end

endmodule
